// File: rtl/otsu_pkg.sv
// -----------------------------------------------------------------------------
// otsu_pkg
//   Shared definitions for the Otsu threshold sweep controller: default
//   datapath widths, candidate count and the sweep FSM state encoding.
// -----------------------------------------------------------------------------
package otsu_pkg;

  localparam int IW_DEF    = 16;   // width of omega / sigma-squared inputs
  localparam int TW_DEF    = 8;    // width of the threshold candidate index
  localparam int NBINS_DEF = 256;  // number of candidates swept

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } sweep_state_t;

endpackage : otsu_pkg

// File: rtl/sigmaW_calc.sv
// -----------------------------------------------------------------------------
// sigmaW_calc
//   Within-class variance for one threshold candidate:
//     sigma_w = omega0*sigma0_sq + omega1*sigma1_sq
//   computed at full width (2*IW+1) so the sum of two maximal products never
//   overflows. Purely combinational.
//
// Ports
//   omega0, sigma0_sq  in  IW       class-0 weight and variance
//   omega1, sigma1_sq  in  IW       class-1 weight and variance
//   sigma_w            out 2*IW+1   weighted variance sum
// -----------------------------------------------------------------------------
module sigmaW_calc #(
  parameter int IW = 16
) (
  input  logic [IW-1:0]  omega0,
  input  logic [IW-1:0]  sigma0_sq,
  input  logic [IW-1:0]  omega1,
  input  logic [IW-1:0]  sigma1_sq,
  output logic [2*IW:0]  sigma_w
);

  logic [2*IW-1:0] prod0;
  logic [2*IW-1:0] prod1;

  // Operands widened before multiplying so the product is formed at 2*IW bits.
  assign prod0   = (2*IW)'(omega0) * (2*IW)'(sigma0_sq);
  assign prod1   = (2*IW)'(omega1) * (2*IW)'(sigma1_sq);
  assign sigma_w = {1'b0, prod0} + {1'b0, prod1};

endmodule : sigmaW_calc

// File: rtl/otsu_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// otsu_sweep_ctrl
//   Sweeps threshold candidates t = 0..NBINS-1. For each candidate it requests
//   class statistics (stat_req/stat_t), waits for stat_valid, registers the
//   four statistics, evaluates the within-class variance and keeps the
//   eligible candidate with the strictly smallest value (ties keep the lower t).
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   start               one-cycle sweep request, ignored while busy
//   busy                sweep in progress (REQ, CMP, DONE)
//   done                one-cycle pulse when the result is valid
//   stat_req, stat_t    statistics request for candidate stat_t
//   stat_valid          statistics inputs valid for stat_t
//   omega0, sigma0_sq,
//   omega1, sigma1_sq   class weights and variances (IW bits each)
//   best_t              candidate with minimum within-class variance
//   best_sigmaW         that minimum (2*IW+1 bits, all-ones if none found)
//   found               at least one eligible candidate seen
// -----------------------------------------------------------------------------
module otsu_sweep_ctrl
  import otsu_pkg::*;
#(
  parameter int IW    = IW_DEF,
  parameter int TW    = TW_DEF,
  parameter int NBINS = NBINS_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          stat_req,
  output logic [TW-1:0] stat_t,
  input  logic          stat_valid,
  input  logic [IW-1:0] omega0,
  input  logic [IW-1:0] sigma0_sq,
  input  logic [IW-1:0] omega1,
  input  logic [IW-1:0] sigma1_sq,
  output logic [TW-1:0] best_t,
  output logic [2*IW:0] best_sigmaW,
  output logic          found
);

  localparam logic [TW-1:0] T_LAST = TW'(NBINS - 1);
  localparam logic [2*IW:0] SW_MAX = '1;

  sweep_state_t    state, state_n;
  logic [TW-1:0]   t_q;
  logic [IW-1:0]   omega0_q, sigma0_sq_q, omega1_q, sigma1_sq_q;
  logic [2*IW:0]   sigma_w;
  logic            accept;
  logic            eligible;
  logic            better;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (start)      state_n = ST_REQ;
      ST_REQ:  if (stat_valid) state_n = ST_CMP;
      ST_CMP:  state_n = (t_q == T_LAST) ? ST_DONE : ST_REQ;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign accept   = (state == ST_REQ) && stat_valid;
  assign eligible = (omega0_q != '0) && (omega1_q != '0);
  // Strict compare: an equal later candidate never displaces an earlier one.
  assign better   = eligible && (sigma_w < best_sigmaW);

  // ---------------------------------------------------------------------------
  // Control state and result registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      t_q         <= '0;
      best_t      <= '0;
      best_sigmaW <= SW_MAX;
      found       <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && start) begin
        t_q         <= '0;
        best_t      <= '0;
        best_sigmaW <= SW_MAX;
        found       <= 1'b0;
      end else if (state == ST_CMP) begin
        if (better) begin
          best_t      <= t_q;
          best_sigmaW <= sigma_w;
          found       <= 1'b1;
        end
        // Leaving CMP at the last candidate goes to DONE, so t never wraps.
        if (t_q != T_LAST) t_q <= t_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // CMP-stage statistic registers
  // ---------------------------------------------------------------------------
  // NOTE: pure datapath registers carry no reset; they are only consumed in
  // CMP, which is always preceded by a load in REQ.
  always_ff @(posedge clk) begin
    if (accept) begin
      omega0_q    <= omega0;
      sigma0_sq_q <= sigma0_sq;
      omega1_q    <= omega1;
      sigma1_sq_q <= sigma1_sq;
    end
  end

  sigmaW_calc #(
    .IW (IW)
  ) u_sigmaW_calc (
    .omega0    (omega0_q),
    .sigma0_sq (sigma0_sq_q),
    .omega1    (omega1_q),
    .sigma1_sq (sigma1_sq_q),
    .sigma_w   (sigma_w)
  );

  // Outputs decode directly from registered state, so they are glitch-free
  // and take their reset values as soon as rst_n falls.
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign stat_req = (state == ST_REQ);
  assign stat_t   = t_q;

endmodule : otsu_sweep_ctrl

// File: tb/tb_otsu_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_otsu_sweep_ctrl
//   Directed bench for otsu_sweep_ctrl with NBINS=4. A responder process
//   answers statistics requests from per-candidate tables after a
//   programmable delay; each test task runs sweeps and checks results inline.
// -----------------------------------------------------------------------------
module tb_otsu_sweep_ctrl;

  localparam int IW    = 16;
  localparam int TW    = 8;
  localparam int NBINS = 4;
  localparam int SWW   = 2*IW + 1;
  localparam logic [SWW-1:0] SW_ONES = '1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          stat_req;
  logic [TW-1:0] stat_t;
  logic          stat_valid;
  logic [IW-1:0] omega0, sigma0_sq, omega1, sigma1_sq;
  logic [TW-1:0] best_t;
  logic [SWW-1:0] best_sigmaW;
  logic          found;

  int n_pass;
  int n_total;

  logic [IW-1:0] tab_o0 [NBINS];
  logic [IW-1:0] tab_s0 [NBINS];
  logic [IW-1:0] tab_o1 [NBINS];
  logic [IW-1:0] tab_s1 [NBINS];
  int            resp_delay;
  bit            stray_mode;

  otsu_sweep_ctrl #(
    .IW    (IW),
    .TW    (TW),
    .NBINS (NBINS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .stat_req    (stat_req),
    .stat_t      (stat_t),
    .stat_valid  (stat_valid),
    .omega0      (omega0),
    .sigma0_sq   (sigma0_sq),
    .omega1      (omega1),
    .sigma1_sq   (sigma1_sq),
    .best_t      (best_t),
    .best_sigmaW (best_sigmaW),
    .found       (found)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Statistics responder: drives on the falling edge, answers after
  // resp_delay waiting cycles; in stray mode it asserts a tempting
  // (sigmaW=0) stat_valid whenever no request is pending.
  initial begin
    int cnt;
    cnt        = 0;
    stat_valid = 1'b0;
    omega0 = '0; sigma0_sq = '0; omega1 = '0; sigma1_sq = '0;
    forever begin
      @(negedge clk);
      if (stat_req === 1'b1) begin
        if (cnt >= resp_delay) begin
          stat_valid = 1'b1;
          omega0     = tab_o0[stat_t[1:0]];
          sigma0_sq  = tab_s0[stat_t[1:0]];
          omega1     = tab_o1[stat_t[1:0]];
          sigma1_sq  = tab_s1[stat_t[1:0]];
        end else begin
          stat_valid = 1'b0;
          omega0 = '0; sigma0_sq = '0; omega1 = '0; sigma1_sq = '0;
          cnt++;
        end
      end else begin
        cnt = 0;
        if (stray_mode) begin
          stat_valid = 1'b1;
          omega0 = 16'd1; sigma0_sq = '0; omega1 = 16'd1; sigma1_sq = '0;
        end else begin
          stat_valid = 1'b0;
        end
      end
    end
  end

  task automatic set_entry(input int idx, input logic [IW-1:0] o0, input logic [IW-1:0] s0,
                           input logic [IW-1:0] o1, input logic [IW-1:0] s1);
    tab_o0[idx] = o0; tab_s0[idx] = s0; tab_o1[idx] = o1; tab_s1[idx] = s1;
  endtask

  // sigmaW per t = {50, 20, 30, 40}, all omegas nonzero.
  task automatic load_basic_tab();
    set_entry(0, 16'd2, 16'd10, 16'd3, 16'd10);
    set_entry(1, 16'd1, 16'd8,  16'd3, 16'd4);
    set_entry(2, 16'd5, 16'd4,  16'd2, 16'd5);
    set_entry(3, 16'd4, 16'd5,  16'd10, 16'd2);
  endtask

  // Issues start and counts cycles until done (start cycle = 0). poke_at>0
  // re-pulses start at that cycle while busy; poke_done pulses start in the
  // DONE cycle. unstable flags any change of stat_req/stat_t while waiting.
  task automatic run_sweep(input int poke_at, input bit poke_done,
                           output int cyc, output bit unstable);
    bit            prev_req;
    logic [TW-1:0] prev_t;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    cyc      = 1;
    unstable = 1'b0;
    prev_req = stat_req;
    prev_t   = stat_t;
    while (done !== 1'b1 && cyc < 200) begin
      start = (poke_at > 0 && cyc == poke_at);
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (prev_req && !stat_valid && (stat_req !== 1'b1 || stat_t !== prev_t)) unstable = 1'b1;
      prev_req = stat_req;
      prev_t   = stat_t;
    end
    // done must last exactly one cycle, and a start in that cycle is ignored.
    start = poke_done;
    @(posedge clk); #1;
    start = 1'b0;
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL done_one_cycle: got done=%0b busy=%0b expected done=0 busy=0", done, busy);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL stays_idle: got busy=%0b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, stat_req, found} !== 4'b0000)
      $display("FAIL reset_flags: got busy/done/req/found=%b expected 0000", {busy, done, stat_req, found});
    else n_pass++;
    n_total++;
    if (stat_t !== '0 || best_t !== '0)
      $display("FAIL reset_idx: got stat_t=%0d best_t=%0d expected 0 0", stat_t, best_t);
    else n_pass++;
    n_total++;
    if (best_sigmaW !== SW_ONES)
      $display("FAIL reset_sigmaW: got %0h expected %0h", best_sigmaW, SW_ONES);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int cyc; bit unst;
    load_basic_tab(); resp_delay = 0;
    run_sweep(4, 1'b1, cyc, unst);
    n_total++;
    if (cyc !== 9) $display("FAIL basic_cycles: got %0d expected 9", cyc); else n_pass++;
    n_total++;
    if (best_t !== 8'd1) $display("FAIL basic_best_t: got %0d expected 1", best_t); else n_pass++;
    n_total++;
    if (best_sigmaW !== 33'd20) $display("FAIL basic_sigmaW: got %0d expected 20", best_sigmaW); else n_pass++;
    n_total++;
    if (found !== 1'b1) $display("FAIL basic_found: got %0b expected 1", found); else n_pass++;
  endtask

  task automatic test_tie_ineligible();
    int cyc; bit unst;
    set_entry(0, 16'd3, 16'd5, 16'd3, 16'd5);  // 30
    set_entry(1, 16'd1, 16'd4, 16'd2, 16'd3);  // 10
    set_entry(2, 16'd2, 16'd2, 16'd3, 16'd2);  // 10, tie
    set_entry(3, 16'd5, 16'd1, 16'd0, 16'd7);  // 5 but omega1=0
    resp_delay = 0;
    run_sweep(0, 1'b0, cyc, unst);
    n_total++;
    if (best_t !== 8'd1) $display("FAIL tie_best_t: got %0d expected 1", best_t); else n_pass++;
    n_total++;
    if (best_sigmaW !== 33'd10) $display("FAIL tie_sigmaW: got %0d expected 10", best_sigmaW); else n_pass++;
  endtask

  task automatic test_delayed();
    int cyc; bit unst;
    load_basic_tab(); resp_delay = 3;
    run_sweep(0, 1'b0, cyc, unst);
    resp_delay = 0;
    n_total++;
    if (cyc !== 5*NBINS + 1) $display("FAIL delayed_cycles: got %0d expected %0d", cyc, 5*NBINS + 1); else n_pass++;
    n_total++;
    if (unst !== 1'b0) $display("FAIL delayed_req_stable: got unstable=%0b expected 0", unst); else n_pass++;
    n_total++;
    if (best_t !== 8'd1 || best_sigmaW !== 33'd20)
      $display("FAIL delayed_result: got t=%0d sw=%0d expected t=1 sw=20", best_t, best_sigmaW);
    else n_pass++;
  endtask

  task automatic test_stray_valid();
    int cyc; bit unst;
    load_basic_tab(); resp_delay = 2; stray_mode = 1'b1;
    run_sweep(0, 1'b0, cyc, unst);
    stray_mode = 1'b0; resp_delay = 0;
    n_total++;
    if (cyc !== 4*NBINS + 1) $display("FAIL stray_cycles: got %0d expected %0d", cyc, 4*NBINS + 1); else n_pass++;
    n_total++;
    if (best_t !== 8'd1 || best_sigmaW !== 33'd20)
      $display("FAIL stray_result: got t=%0d sw=%0d expected t=1 sw=20", best_t, best_sigmaW);
    else n_pass++;
  endtask

  task automatic test_none_eligible();
    int cyc; bit unst; int dones;
    for (int i = 0; i < NBINS; i++) set_entry(i, 16'd0, 16'd9, 16'd4, 16'd3);
    run_sweep(0, 1'b0, cyc, unst);
    n_total++;
    if (found !== 1'b0 || best_t !== '0 || best_sigmaW !== SW_ONES)
      $display("FAIL none_result: got found=%0b t=%0d sw=%0h expected 0 0 %0h", found, best_t, best_sigmaW, SW_ONES);
    else n_pass++;
    n_total++;
    if (cyc !== 9) $display("FAIL none_cycles: got %0d expected 9", cyc); else n_pass++;
    dones = 0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (done === 1'b1) dones++; end
    n_total++;
    if (dones !== 0) $display("FAIL none_extra_done: got %0d pulses expected 0", dones); else n_pass++;
  endtask

  task automatic test_full_width();
    int cyc; bit unst;
    for (int i = 0; i < NBINS; i++) set_entry(i, 16'd0, 16'd1, 16'd1, 16'd1);
    set_entry(2, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    run_sweep(0, 1'b0, cyc, unst);
    n_total++;
    if (best_sigmaW !== 33'h1_FFFC_0002)
      $display("FAIL full_width_sigmaW: got %0h expected 1fffc0002", best_sigmaW);
    else n_pass++;
    n_total++;
    if (best_t !== 8'd2 || found !== 1'b1)
      $display("FAIL full_width_t: got t=%0d found=%0b expected 2 1", best_t, found);
    else n_pass++;
  endtask

  task automatic test_reset_mid_sweep();
    int cyc; bit unst; int wait_cyc; int dones;
    load_basic_tab(); resp_delay = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_cyc = 0;
    while (!(stat_req === 1'b1 && stat_t === 8'd2) && wait_cyc < 50) begin
      @(posedge clk); #1; wait_cyc++;
    end
    n_total++;
    if (wait_cyc >= 50) $display("FAIL mid_reach_t2: got timeout expected stat_t=2"); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, stat_req, found} !== 4'b0000 || stat_t !== '0 || best_sigmaW !== SW_ONES)
      $display("FAIL mid_async_reset: got b/d/r/f=%b stat_t=%0d sw=%0h expected 0000 0 %0h",
               {busy, done, stat_req, found}, stat_t, best_sigmaW, SW_ONES);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) dones++; end
    n_total++;
    if (dones !== 0) $display("FAIL mid_no_done: got %0d active cycles expected 0", dones); else n_pass++;
    run_sweep(3, 1'b0, cyc, unst);
    n_total++;
    if (cyc !== 9 || best_t !== 8'd1 || best_sigmaW !== 33'd20 || found !== 1'b1)
      $display("FAIL mid_new_sweep: got cyc=%0d t=%0d sw=%0d found=%0b expected 9 1 20 1",
               cyc, best_t, best_sigmaW, found);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    resp_delay = 0; stray_mode = 1'b0;
    start = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < NBINS; i++) set_entry(i, '0, '0, '0, '0);
    test_reset();
    test_basic();
    test_tie_ineligible();
    test_delayed();
    test_stray_valid();
    test_full_width();
    test_none_eligible();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_otsu_sweep_ctrl
